// File: rtl/video_pll_pkg.sv
// Shared constants for the video PLL reset sequencer.
// State encoding, counter width, default timing and a saturating helper.
package video_pll_pkg;

  localparam int CNT_W = 17;

  typedef logic [2:0] state_t;

  localparam state_t ST_RESET     = 3'd0;
  localparam state_t ST_WAIT_LOCK = 3'd1;
  localparam state_t ST_STABLE    = 3'd2;
  localparam state_t ST_RUN       = 3'd3;
  localparam state_t ST_FAIL      = 3'd4;

  localparam int DEF_RST_CYCLES   = 64;
  localparam int DEF_LOCK_TIMEOUT = 100000;
  localparam int DEF_LOCK_STABLE  = 1024;
  localparam int DEF_MAX_RETRY    = 7;

  function automatic logic [3:0] sat_inc4(
    input logic [3:0] v
  );
    return (v == 4'hf) ? v : v + 4'd1;
  endfunction

endpackage

// File: rtl/video_pll_rst_ctrl_sync_2ff.sv
// Generic two-flop synchronizer, async active-low reset to zero.
// Ports: clk, rst_n, d (async input), q (synchronized output).
module sync_2ff #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta_q;
  logic [W-1:0] sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/video_pll_rst_ctrl.sv
// Video PLL reset sequencer: PLL reset, lock qualification, retries.
// Ports: clk, rst_n, pll_lock, relock_req in; pll_rst, video_rst_n, pll_ready, pll_fail, retry_cnt, lock_lost out.
module video_pll_rst_ctrl
  import video_pll_pkg::*;
#(
  parameter int RST_CYCLES   = DEF_RST_CYCLES,
  parameter int LOCK_TIMEOUT = DEF_LOCK_TIMEOUT,
  parameter int LOCK_STABLE  = DEF_LOCK_STABLE,
  parameter int MAX_RETRY    = DEF_MAX_RETRY
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       pll_lock,
  input  logic       relock_req,
  output logic       pll_rst,
  output logic       video_rst_n,
  output logic       pll_ready,
  output logic       pll_fail,
  output logic [3:0] retry_cnt,
  output logic       lock_lost
);

  localparam logic [CNT_W-1:0] RST_LAST =
    CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] TO_LAST =
    CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] STB_LAST =
    CNT_W'(LOCK_STABLE - 1);
  localparam logic [3:0] RETRY_MAX =
    4'(MAX_RETRY);

  logic lock_s;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       retry_q, retry_d;
  logic [3:0]       retry_inc;
  logic             pll_rst_q, pll_rst_d;
  logic             vrst_n_q, vrst_n_d;
  logic             ready_q, ready_d;
  logic             fail_q, fail_d;
  logic             lost_q, lost_d;

  sync_2ff #(
    .W (1)
  ) u_lock_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (pll_lock),
    .q     (lock_s)
  );

  assign retry_inc = sat_inc4(retry_q);

  always_comb begin
    state_d = state_q;
    retry_d = retry_q;
    lost_d  = 1'b0;
    unique case (state_q)
      ST_RESET: begin
        if (cnt_q == RST_LAST)
          state_d = ST_WAIT_LOCK;
      end
      ST_WAIT_LOCK: begin
        // a lock seen on the timeout cycle beats the retry
        if (lock_s) begin
          state_d = ST_STABLE;
        end else if (cnt_q == TO_LAST) begin
          retry_d = retry_inc;
          state_d = (retry_inc > RETRY_MAX) ?
                    ST_FAIL : ST_RESET;
        end
      end
      ST_STABLE: begin
        if (!lock_s) begin
          state_d = ST_WAIT_LOCK;
        end else if (cnt_q == STB_LAST) begin
          state_d = ST_RUN;
          retry_d = 4'd0;
        end
      end
      ST_RUN: begin
        if (!lock_s) begin
          state_d = ST_RESET;
          lost_d  = 1'b1;
        end
      end
      ST_FAIL: begin
        state_d = ST_FAIL;
      end
      default: begin
        state_d = ST_RESET;
      end
    endcase
    if (relock_req) begin
      state_d = ST_RESET;
      retry_d = 4'd0;
      lost_d  = 1'b0;
    end
  end

  // STABLE->WAIT_LOCK also counts as an entry, so it clears too
  always_comb begin
    cnt_d = cnt_q + CNT_W'(1);
    if (state_d != state_q || relock_req)
      cnt_d = '0;
    else if (state_q == ST_RUN || state_q == ST_FAIL)
      cnt_d = cnt_q;
  end

  // outputs decode the next state so they line up with it
  always_comb begin
    pll_rst_d = (state_d == ST_RESET) ||
                (state_d == ST_FAIL);
    vrst_n_d  = (state_d == ST_RUN);
    ready_d   = (state_d == ST_RUN);
    fail_d    = (state_d == ST_FAIL);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_RESET;
      cnt_q     <= '0;
      retry_q   <= 4'd0;
      pll_rst_q <= 1'b1;
      vrst_n_q  <= 1'b0;
      ready_q   <= 1'b0;
      fail_q    <= 1'b0;
      lost_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      retry_q   <= retry_d;
      pll_rst_q <= pll_rst_d;
      vrst_n_q  <= vrst_n_d;
      ready_q   <= ready_d;
      fail_q    <= fail_d;
      lost_q    <= lost_d;
    end
  end

  assign pll_rst     = pll_rst_q;
  assign video_rst_n = vrst_n_q;
  assign pll_ready   = ready_q;
  assign pll_fail    = fail_q;
  assign retry_cnt   = retry_q;
  assign lock_lost   = lost_q;

endmodule

// File: tb/tb_video_pll_rst_ctrl.sv
// Bench for video_pll_rst_ctrl: scoreboard of timed output events.
// Small timing parameters so every scenario stays short.
`timescale 1ns/100ps
module tb_video_pll_rst_ctrl;

  logic       clk;
  logic       rst_n;
  logic       pll_lock;
  logic       relock_req;
  logic       pll_rst;
  logic       video_rst_n;
  logic       pll_ready;
  logic       pll_fail;
  logic [3:0] retry_cnt;
  logic       lock_lost;

  typedef enum int {
    EV_PRST_FALL = 0,
    EV_RDY_RISE  = 1,
    EV_LOST      = 2,
    EV_FAIL_RISE = 3
  } ev_t;

  typedef struct {
    ev_t kind;
    int  cyc;
  } exp_t;

  exp_t exp_q[$];
  int   cyc = 0;
  int   vectors = 0;
  int   miscompares = 0;

  video_pll_rst_ctrl #(
    .RST_CYCLES   (4),
    .LOCK_TIMEOUT (32),
    .LOCK_STABLE  (8),
    .MAX_RETRY    (2)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .pll_lock    (pll_lock),
    .relock_req  (relock_req),
    .pll_rst     (pll_rst),
    .video_rst_n (video_rst_n),
    .pll_ready   (pll_ready),
    .pll_fail    (pll_fail),
    .retry_cnt   (retry_cnt),
    .lock_lost   (lock_lost)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  // cyc = number of rising edges seen so far
  always @(posedge clk) cyc <= cyc + 1;

  logic prev_rst, prev_rdy, prev_fail;

  // monitor: each observed event pops and checks the scoreboard
  always @(posedge clk) begin
    ev_t  obs[$];
    exp_t e;
    #1;
    obs = {};
    if (lock_lost === 1'b1) obs.push_back(EV_LOST);
    if (prev_rst === 1'b1 && pll_rst === 1'b0)
      obs.push_back(EV_PRST_FALL);
    if (prev_rdy === 1'b0 && pll_ready === 1'b1)
      obs.push_back(EV_RDY_RISE);
    if (prev_fail === 1'b0 && pll_fail === 1'b1)
      obs.push_back(EV_FAIL_RISE);
    prev_rst  = pll_rst;
    prev_rdy  = pll_ready;
    prev_fail = pll_fail;
    foreach (obs[i]) begin
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL sb_unexpected: event %0d at cycle %0d, none expected",
                 obs[i], cyc);
      end else begin
        e = exp_q.pop_front();
        if (e.kind !== obs[i] || e.cyc !== cyc) begin
          miscompares++;
          $display("FAIL sb_event: got event %0d at cycle %0d, expected event %0d at cycle %0d",
                   obs[i], cyc, e.kind, e.cyc);
        end
      end
    end
  end

  task automatic to_neg(input int n);
    while (cyc < n) @(negedge clk);
  endtask

  task automatic push(input ev_t k, input int c);
    exp_t e;
    e.kind = k;
    e.cyc  = c;
    exp_q.push_back(e);
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    pll_lock = 1'b0;
    relock_req = 1'b0;
    to_neg(2);
    vectors += 6;
    if (pll_rst !== 1'b1) begin miscompares++;
      $display("FAIL rst_pll_rst: got %b expected 1", pll_rst); end
    if (video_rst_n !== 1'b0) begin miscompares++;
      $display("FAIL rst_video_rst_n: got %b expected 0", video_rst_n); end
    if (pll_ready !== 1'b0) begin miscompares++;
      $display("FAIL rst_ready: got %b expected 0", pll_ready); end
    if (pll_fail !== 1'b0) begin miscompares++;
      $display("FAIL rst_fail: got %b expected 0", pll_fail); end
    if (retry_cnt !== 4'd0) begin miscompares++;
      $display("FAIL rst_retry: got %0d expected 0", retry_cnt); end
    if (lock_lost !== 1'b0) begin miscompares++;
      $display("FAIL rst_lost: got %b expected 0", lock_lost); end
  endtask

  // lock changes half a cycle before edge W+20 (W = pll_rst fall)
  task automatic test_normal_lock;
    int k;
    k = cyc;
    rst_n = 1'b1;
    push(EV_PRST_FALL, k + 4);
    push(EV_RDY_RISE, k + 34);
    to_neg(k + 3);
    vectors++;
    if (pll_rst !== 1'b1) begin miscompares++;
      $display("FAIL norm_rst_held: got %b expected 1", pll_rst); end
    to_neg(k + 23);
    pll_lock = 1'b1;
    to_neg(k + 33);
    vectors++;
    if (pll_ready !== 1'b0) begin miscompares++;
      $display("FAIL norm_ready_early: got %b expected 0", pll_ready); end
    to_neg(k + 34);
    vectors += 3;
    if (pll_ready !== 1'b1) begin miscompares++;
      $display("FAIL norm_ready: got %b expected 1", pll_ready); end
    if (video_rst_n !== 1'b1) begin miscompares++;
      $display("FAIL norm_vrst: got %b expected 1", video_rst_n); end
    if (retry_cnt !== 4'd0) begin miscompares++;
      $display("FAIL norm_retry: got %0d expected 0", retry_cnt); end
    vectors++;
    if (exp_q.size() !== 0) begin miscompares++;
      $display("FAIL norm_drain: got %0d pending expected 0", exp_q.size()); end
  endtask

  task automatic test_lock_glitch;
    int r;
    relock_req = 1'b1;
    r = cyc + 1;
    to_neg(r);
    relock_req = 1'b0;
    push(EV_PRST_FALL, r + 4);
    push(EV_RDY_RISE, r + 21);
    to_neg(r + 7);
    pll_lock = 1'b0;
    to_neg(r + 10);
    pll_lock = 1'b1;
    to_neg(r + 20);
    vectors += 3;
    if (pll_ready !== 1'b0) begin miscompares++;
      $display("FAIL glitch_ready_early: got %b expected 0", pll_ready); end
    if (pll_rst !== 1'b0) begin miscompares++;
      $display("FAIL glitch_pll_rst: got %b expected 0", pll_rst); end
    if (retry_cnt !== 4'd0) begin miscompares++;
      $display("FAIL glitch_retry: got %0d expected 0", retry_cnt); end
    to_neg(r + 21);
    vectors += 2;
    if (pll_ready !== 1'b1) begin miscompares++;
      $display("FAIL glitch_ready: got %b expected 1", pll_ready); end
    if (exp_q.size() !== 0) begin miscompares++;
      $display("FAIL glitch_drain: got %0d pending expected 0", exp_q.size()); end
  endtask

  // relock lands on the cycle STABLE would hand over to RUN
  task automatic test_relock_vs_run;
    int r;
    relock_req = 1'b1;
    r = cyc + 1;
    to_neg(r);
    relock_req = 1'b0;
    push(EV_PRST_FALL, r + 4);
    push(EV_PRST_FALL, r + 17);
    push(EV_RDY_RISE, r + 26);
    to_neg(r + 12);
    relock_req = 1'b1;
    to_neg(r + 13);
    relock_req = 1'b0;
    vectors += 2;
    if (pll_ready !== 1'b0) begin miscompares++;
      $display("FAIL relock_run_ready: got %b expected 0", pll_ready); end
    if (pll_rst !== 1'b1) begin miscompares++;
      $display("FAIL relock_run_pll_rst: got %b expected 1", pll_rst); end
    to_neg(r + 26);
    vectors += 2;
    if (pll_ready !== 1'b1) begin miscompares++;
      $display("FAIL relock_run_ready2: got %b expected 1", pll_ready); end
    if (exp_q.size() !== 0) begin miscompares++;
      $display("FAIL relock_run_drain: got %0d pending expected 0", exp_q.size()); end
  endtask

  task automatic test_loss_of_lock;
    int b;
    b = cyc;
    pll_lock = 1'b0;
    push(EV_LOST, b + 3);
    push(EV_PRST_FALL, b + 7);
    push(EV_RDY_RISE, b + 16);
    to_neg(b + 2);
    vectors += 2;
    if (pll_ready !== 1'b1) begin miscompares++;
      $display("FAIL lost_ready_hold: got %b expected 1", pll_ready); end
    if (lock_lost !== 1'b0) begin miscompares++;
      $display("FAIL lost_early: got %b expected 0", lock_lost); end
    to_neg(b + 3);
    vectors += 3;
    if (lock_lost !== 1'b1) begin miscompares++;
      $display("FAIL lost_pulse: got %b expected 1", lock_lost); end
    if (video_rst_n !== 1'b0) begin miscompares++;
      $display("FAIL lost_vrst: got %b expected 0", video_rst_n); end
    if (pll_rst !== 1'b1) begin miscompares++;
      $display("FAIL lost_pll_rst: got %b expected 1", pll_rst); end
    to_neg(b + 4);
    pll_lock = 1'b1;
    vectors++;
    if (lock_lost !== 1'b0) begin miscompares++;
      $display("FAIL lost_width: got %b expected 0", lock_lost); end
    to_neg(b + 16);
    vectors += 2;
    if (pll_ready !== 1'b1) begin miscompares++;
      $display("FAIL lost_relock: got %b expected 1", pll_ready); end
    if (exp_q.size() !== 0) begin miscompares++;
      $display("FAIL lost_drain: got %0d pending expected 0", exp_q.size()); end
  endtask

  // lock_s first high exactly on the last WAIT_LOCK cycle
  task automatic test_lock_on_timeout;
    int b, w;
    b = cyc;
    w = b + 7;
    pll_lock = 1'b0;
    push(EV_LOST, b + 3);
    push(EV_PRST_FALL, w);
    push(EV_RDY_RISE, w + 40);
    to_neg(w + 29);
    pll_lock = 1'b1;
    to_neg(w + 32);
    vectors += 2;
    if (pll_rst !== 1'b0) begin miscompares++;
      $display("FAIL to_edge_pll_rst: got %b expected 0", pll_rst); end
    if (retry_cnt !== 4'd0) begin miscompares++;
      $display("FAIL to_edge_retry: got %0d expected 0", retry_cnt); end
    to_neg(w + 40);
    vectors += 3;
    if (pll_ready !== 1'b1) begin miscompares++;
      $display("FAIL to_edge_ready: got %b expected 1", pll_ready); end
    if (retry_cnt !== 4'd0) begin miscompares++;
      $display("FAIL to_edge_retry2: got %0d expected 0", retry_cnt); end
    if (exp_q.size() !== 0) begin miscompares++;
      $display("FAIL to_edge_drain: got %0d pending expected 0", exp_q.size()); end
  endtask

  task automatic test_timeout_retries;
    int b, c;
    b = cyc;
    pll_lock = 1'b0;
    push(EV_LOST, b + 3);
    push(EV_PRST_FALL, b + 7);
    push(EV_PRST_FALL, b + 43);
    push(EV_PRST_FALL, b + 79);
    push(EV_FAIL_RISE, b + 111);
    to_neg(b + 40);
    vectors += 2;
    if (retry_cnt !== 4'd1) begin miscompares++;
      $display("FAIL retry_first: got %0d expected 1", retry_cnt); end
    if (pll_rst !== 1'b1) begin miscompares++;
      $display("FAIL retry_pll_rst: got %b expected 1", pll_rst); end
    to_neg(b + 112);
    vectors += 3;
    if (pll_fail !== 1'b1) begin miscompares++;
      $display("FAIL retry_fail: got %b expected 1", pll_fail); end
    if (retry_cnt !== 4'd3) begin miscompares++;
      $display("FAIL retry_cnt3: got %0d expected 3", retry_cnt); end
    if (pll_rst !== 1'b1) begin miscompares++;
      $display("FAIL retry_fail_rst: got %b expected 1", pll_rst); end
    to_neg(b + 140);
    vectors += 2;
    if (pll_fail !== 1'b1) begin miscompares++;
      $display("FAIL retry_sticky: got %b expected 1", pll_fail); end
    if (pll_rst !== 1'b1) begin miscompares++;
      $display("FAIL retry_rst_held: got %b expected 1", pll_rst); end
    c = cyc;
    relock_req = 1'b1;
    push(EV_PRST_FALL, c + 5);
    push(EV_RDY_RISE, c + 14);
    to_neg(c + 1);
    relock_req = 1'b0;
    vectors += 3;
    if (pll_fail !== 1'b0) begin miscompares++;
      $display("FAIL relock_fail_clr: got %b expected 0", pll_fail); end
    if (retry_cnt !== 4'd0) begin miscompares++;
      $display("FAIL relock_retry_clr: got %0d expected 0", retry_cnt); end
    if (pll_rst !== 1'b1) begin miscompares++;
      $display("FAIL relock_pll_rst: got %b expected 1", pll_rst); end
    to_neg(c + 2);
    pll_lock = 1'b1;
    to_neg(c + 14);
    vectors += 2;
    if (pll_ready !== 1'b1) begin miscompares++;
      $display("FAIL relock_ready: got %b expected 1", pll_ready); end
    if (exp_q.size() !== 0) begin miscompares++;
      $display("FAIL retry_drain: got %0d pending expected 0", exp_q.size()); end
  endtask

  task automatic test_async_reset;
    int b;
    b = cyc;
    rst_n = 1'b0;
    #1;
    vectors += 5;
    if (pll_rst !== 1'b1) begin miscompares++;
      $display("FAIL arst_pll_rst: got %b expected 1", pll_rst); end
    if (video_rst_n !== 1'b0) begin miscompares++;
      $display("FAIL arst_vrst: got %b expected 0", video_rst_n); end
    if (pll_ready !== 1'b0) begin miscompares++;
      $display("FAIL arst_ready: got %b expected 0", pll_ready); end
    if (pll_fail !== 1'b0) begin miscompares++;
      $display("FAIL arst_fail: got %b expected 0", pll_fail); end
    if (retry_cnt !== 4'd0) begin miscompares++;
      $display("FAIL arst_retry: got %0d expected 0", retry_cnt); end
    rst_n = 1'b1;
    push(EV_PRST_FALL, b + 4);
    push(EV_RDY_RISE, b + 13);
    to_neg(b + 12);
    vectors++;
    if (pll_ready !== 1'b0) begin miscompares++;
      $display("FAIL arst_ready_early: got %b expected 0", pll_ready); end
    to_neg(b + 13);
    vectors += 2;
    if (pll_ready !== 1'b1) begin miscompares++;
      $display("FAIL arst_ready2: got %b expected 1", pll_ready); end
    if (exp_q.size() !== 0) begin miscompares++;
      $display("FAIL arst_drain: got %0d pending expected 0", exp_q.size()); end
  endtask

  initial begin
    test_reset();
    test_normal_lock();
    test_lock_glitch();
    test_relock_vs_run();
    test_loss_of_lock();
    test_lock_on_timeout();
    test_timeout_retries();
    test_async_reset();
    to_neg(cyc + 3);
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
